// File: rtl/max_pool_2x2_stride_2x2_pkg.sv
// Shared FP32 pooling definitions: word width, total-order key and pooled dimensions.
package max_pool_2x2_stride_2x2_pkg;

    localparam int unsigned FP32_W = 32;

    typedef logic [FP32_W-1:0] fp32_t;

    typedef struct packed {
        logic  valid;
        fp32_t data;
    } pool_beat_t;

    // Maps FP32 onto an unsigned key so that -0 < +0 and negatives order correctly.
    function automatic fp32_t fp32_key(input fp32_t x);
        return x[FP32_W-1] ? ~x : (x ^ {1'b1, {(FP32_W-1){1'b0}}});
    endfunction

    function automatic int unsigned pool_out_dim(input int unsigned n);
        return n / 2;
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/max_pool_2x2_stride_2x2_fp32_max.sv
// Combinational maximum of two FP32 values under the shared ordering key.
module max_pool_2x2_stride_2x2_fp32_max
    import max_pool_2x2_stride_2x2_pkg::*;
(
    input  fp32_t a,
    input  fp32_t b,
    output fp32_t max_c
);

    assign max_c = (fp32_key(b) > fp32_key(a)) ? b : a;

endmodule

// File: rtl/max_pool_2x2_stride_2x2.sv
// 2x2 stride-2 max pooling over a raster-ordered, valid-only FP32 stream.
module max_pool_2x2_stride_2x2
    import max_pool_2x2_stride_2x2_pkg::*;
#(
    parameter int unsigned IMG_HEIGHT = 150,
    parameter int unsigned IMG_WIDHT  = 150
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FP32_W-1:0] Data_In,
    input  logic              Valid_In,
    output logic [FP32_W-1:0] Data_Out,
    output logic              Valid_Out
);

    localparam int unsigned OUT_W    = pool_out_dim(IMG_WIDHT);
    localparam int unsigned COL_W    = idx_width(IMG_WIDHT);
    localparam int unsigned ROW_W    = idx_width(IMG_HEIGHT);
    localparam int unsigned K_W      = idx_width(OUT_W);
    localparam int unsigned LB_DEPTH = (OUT_W > 1) ? OUT_W : 2;

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    fp32_t            pair_q;
    pool_beat_t       out_q;
    fp32_t            linebuf [LB_DEPTH];

    logic [K_W-1:0]   k_c;
    logic             last_col_c;
    logic             last_row_c;
    fp32_t            lb_rd_c;
    fp32_t            h_max_c;
    fp32_t            v_max_c;

    assign k_c        = K_W'(col >> 1);
    assign last_col_c = (col == COL_W'(IMG_WIDHT - 1));
    assign last_row_c = (row == ROW_W'(IMG_HEIGHT - 1));
    assign lb_rd_c    = linebuf[k_c];

    max_pool_2x2_stride_2x2_fp32_max u_h_max (
        .a     (pair_q),
        .b     (Data_In),
        .max_c (h_max_c)
    );

    max_pool_2x2_stride_2x2_fp32_max u_v_max (
        .a     (h_max_c),
        .b     (lb_rd_c),
        .max_c (v_max_c)
    );

    // Raster position, horizontal pair latch and pooled output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col    <= '0;
            row    <= '0;
            pair_q <= '0;
            out_q  <= '0;
        end else begin
            out_q.valid <= 1'b0;
            if (Valid_In) begin
                if (last_col_c) begin
                    col <= '0;
                    row <= last_row_c ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end

                if (!col[0]) begin
                    pair_q <= Data_In;
                end else if (row[0]) begin
                    out_q.valid <= 1'b1;
                    out_q.data  <= v_max_c;
                end
            end
        end
    end

    // Even rows park their horizontal maxima until the odd row arrives; never read before written.
    always_ff @(posedge clk) begin
        if (Valid_In && col[0] && !row[0]) begin
            linebuf[k_c] <= h_max_c;
        end
    end

    assign Data_Out  = out_q.data;
    assign Valid_Out = out_q.valid;

endmodule

// File: tb/tb_max_pool_2x2_stride_2x2.sv
// Scoreboard bench for the 2x2 max pool on 4x4, 2x2 and 5x5 instances.
module tb_max_pool_2x2_stride_2x2;

    typedef struct {
        logic [31:0] d;
        longint      due;
    } sb_t;

    logic        clk;
    logic        rst;
    logic [31:0] din  [3];
    logic        vin  [3];
    logic [31:0] dout [3];
    logic        vout [3];

    sb_t    q [3][$];
    int     pulses [3];
    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;

    max_pool_2x2_stride_2x2 #(.IMG_HEIGHT(4), .IMG_WIDHT(4)) u_p4 (
        .clk(clk), .rst(rst), .Data_In(din[0]), .Valid_In(vin[0]),
        .Data_Out(dout[0]), .Valid_Out(vout[0]));

    max_pool_2x2_stride_2x2 #(.IMG_HEIGHT(2), .IMG_WIDHT(2)) u_p2 (
        .clk(clk), .rst(rst), .Data_In(din[1]), .Valid_In(vin[1]),
        .Data_Out(dout[1]), .Valid_Out(vout[1]));

    max_pool_2x2_stride_2x2 #(.IMG_HEIGHT(5), .IMG_WIDHT(5)) u_p5 (
        .clk(clk), .rst(rst), .Data_In(din[2]), .Valid_In(vin[2]),
        .Data_Out(dout[2]), .Valid_Out(vout[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Integer to FP32 bit pattern (magnitudes well under 2^23).
    function automatic logic [31:0] fp(input int n);
        int          a;
        int          e;
        logic [31:0] r;
        a = (n < 0) ? -n : n;
        e = 0;
        if (a == 0) return 32'h0000_0000;
        while ((a >> (e + 1)) != 0) e++;
        r = {(n < 0), 8'(127 + e), 23'(a << (23 - e))};
        return r;
    endfunction

    function automatic logic [31:0] tkey(input logic [31:0] x);
        return x[31] ? ~x : {~x[31], x[30:0]};
    endfunction

    function automatic logic [31:0] kmax(input logic [31:0] a, input logic [31:0] b);
        return (tkey(b) > tkey(a)) ? b : a;
    endfunction

    // Output monitor: every pulse must match the scoreboard head in value and cycle.
    always @(negedge clk) begin
        sb_t e;
        if (rst) begin
            for (int s = 0; s < 3; s++) begin
                if (vout[s]) begin
                    pulses[s]++;
                    checks++;
                    if (q[s].size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_pulse dut=%0d got=%h cyc=%0d", s, dout[s], cyc);
                    end else begin
                        e = q[s].pop_front();
                        if (dout[s] !== e.d || cyc != e.due) begin
                            failures++;
                            $display("FAIL pooled_value dut=%0d got=%h@%0d want=%h@%0d",
                                     s, dout[s], cyc, e.d, e.due);
                        end
                    end
                end else if (q[s].size() != 0 && q[s][0].due <= cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL missing_pulse dut=%0d want=%h@%0d cyc=%0d",
                             s, q[s][0].d, q[s][0].due, cyc);
                    void'(q[s].pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic drive_frame(input int s, input int w, input logic [31:0] px [25],
                               input bit gaps, input int npx);
        sb_t e;
        int  r;
        int  c;
        for (int i = 0; i < npx; i++) begin
            r = i / w;
            c = i % w;
            if (gaps) begin
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    vin[s] = 1'b0;
                    din[s] = $urandom;
                end
            end
            @(negedge clk);
            din[s] = px[i];
            vin[s] = 1'b1;
            if ((r % 2) == 1 && (c % 2) == 1) begin
                e.d   = kmax(kmax(px[i - w - 1], px[i - w]), kmax(px[i - 1], px[i]));
                e.due = cyc + 1;
                q[s].push_back(e);
            end
        end
    endtask

    task automatic idle(input int s, input int n);
        @(negedge clk);
        vin[s] = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic ramp(output logic [31:0] f [25], input int base);
        for (int i = 0; i < 25; i++) f[i] = fp(base + i);
    endtask

    task automatic test_reset();
        #1;
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (vout[s] !== 1'b0 || dout[s] !== 32'h0) begin
                failures++;
                $display("FAIL reset_outputs dut=%0d got v=%b d=%h want v=0 d=0", s, vout[s], dout[s]);
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] f [25];
        int          p0;
        p0 = pulses[0];
        ramp(f, 1);
        drive_frame(0, 4, f, 1'b0, 16);
        idle(0, 4);
        checks++;
        if (pulses[0] - p0 != 4 || q[0].size() != 0) begin
            failures++;
            $display("FAIL basic_count got=%0d pending=%0d want=4", pulses[0] - p0, q[0].size());
        end
        checks++;
        if (dout[0] !== fp(16)) begin
            failures++;
            $display("FAIL basic_hold got=%h want=%h", dout[0], fp(16));
        end
    endtask

    task automatic test_gaps();
        logic [31:0] f [25];
        int          p0;
        p0 = pulses[0];
        ramp(f, 1);
        drive_frame(0, 4, f, 1'b1, 16);
        idle(0, 4);
        checks++;
        if (pulses[0] - p0 != 4 || q[0].size() != 0) begin
            failures++;
            $display("FAIL gaps_count got=%0d pending=%0d want=4", pulses[0] - p0, q[0].size());
        end
    endtask

    task automatic test_sign();
        logic [31:0] f [25];
        f = '{default: 32'h0};
        f[0] = fp(-3); f[1] = 32'h8000_0000; f[2] = 32'h0000_0000; f[3] = fp(-1);
        drive_frame(1, 2, f, 1'b0, 4);
        idle(1, 3);
        checks++;
        if (dout[1] !== 32'h0000_0000) begin
            failures++;
            $display("FAIL sign_zero got=%h want=00000000", dout[1]);
        end
        f[0] = fp(-5); f[1] = fp(-2); f[2] = fp(-7); f[3] = fp(-9);
        drive_frame(1, 2, f, 1'b0, 4);
        idle(1, 3);
        checks++;
        if (dout[1] !== 32'hC000_0000) begin
            failures++;
            $display("FAIL sign_neg got=%h want=c0000000", dout[1]);
        end
    endtask

    task automatic test_odd_dims();
        logic [31:0] f [25];
        int          p0;
        p0 = pulses[2];
        ramp(f, 1);
        drive_frame(2, 5, f, 1'b0, 25);
        idle(2, 4);
        checks++;
        if (pulses[2] - p0 != 4 || q[2].size() != 0) begin
            failures++;
            $display("FAIL odd_count got=%0d pending=%0d want=4", pulses[2] - p0, q[2].size());
        end
        checks++;
        if (dout[2] !== fp(19)) begin
            failures++;
            $display("FAIL odd_last got=%h want=%h", dout[2], fp(19));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] f [25];
        int          p0;
        p0 = pulses[0];
        ramp(f, 1);
        drive_frame(0, 4, f, 1'b0, 16);
        ramp(f, 101);
        drive_frame(0, 4, f, 1'b0, 16);
        idle(0, 4);
        checks++;
        if (pulses[0] - p0 != 8 || q[0].size() != 0) begin
            failures++;
            $display("FAIL b2b_count got=%0d pending=%0d want=8", pulses[0] - p0, q[0].size());
        end
        checks++;
        if (dout[0] !== fp(116)) begin
            failures++;
            $display("FAIL b2b_last got=%h want=%h", dout[0], fp(116));
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] f [25];
        int          p0;
        ramp(f, 1);
        drive_frame(0, 4, f, 1'b0, 7);
        @(negedge clk);
        vin[0] = 1'b0;
        rst    = 1'b0;
        #1;
        checks++;
        if (vout[0] !== 1'b0 || dout[0] !== 32'h0) begin
            failures++;
            $display("FAIL midreset_outputs got v=%b d=%h want v=0 d=0", vout[0], dout[0]);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (vout[0] !== 1'b0 || q[0].size() != 0) begin
            failures++;
            $display("FAIL midreset_hold got v=%b pending=%0d want v=0 pending=0", vout[0], q[0].size());
        end
        for (int s = 0; s < 3; s++) q[s].delete();
        rst = 1'b1;
        p0  = pulses[0];
        drive_frame(0, 4, f, 1'b0, 16);
        idle(0, 4);
        checks++;
        if (pulses[0] - p0 != 4 || q[0].size() != 0) begin
            failures++;
            $display("FAIL midreset_count got=%0d pending=%0d want=4", pulses[0] - p0, q[0].size());
        end
    endtask

    initial begin
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            din[s]    = 32'h0;
            vin[s]    = 1'b0;
            pulses[s] = 0;
        end
        repeat (3) @(negedge clk);
        test_reset();
        @(negedge clk);
        rst = 1'b1;
        test_basic();
        test_gaps();
        test_sign();
        test_odd_dims();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
